// File: rtl/vmask_pop_ctrl_if.sv
// ----------------------------------------------------------------------------
// vmask_pop_ctrl_if
//   Bundles the signals of the vcpop.m sequencer: the request channel from
//   vALU issue, the mask beat stream, the popcount datapath hookup and the
//   result channel.
//
//   Modports:
//     slave  - the sequencer (vmask_pop_ctrl)
//     master - the surrounding logic (issue, beat source, datapath, consumer)
//
//   Signals:
//     req_valid/req_ready/req_vl       request carrying vl
//     beat_valid/beat_ready/beat_data  mask beats, bit 0 = lowest element
//     pc_m0/pc_valid/pc_count/pc_sum   popcount datapath mask/count/sum
//     res_valid/res_ready/res_data     final count
//     req_vm, beat_v0                  only with VMASK_POP_VM_EN defined
// ----------------------------------------------------------------------------
interface vmask_pop_ctrl_if #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned VL_WIDTH        = 12,
    parameter int unsigned RESP_DATA_WIDTH = 64
);
    logic                       req_valid;
    logic                       req_ready;
    logic [VL_WIDTH-1:0]        req_vl;
    logic                       beat_valid;
    logic                       beat_ready;
    logic [DATA_WIDTH-1:0]      beat_data;
    logic [DATA_WIDTH-1:0]      pc_m0;
    logic                       pc_valid;
    logic [RESP_DATA_WIDTH-1:0] pc_count;
    logic [RESP_DATA_WIDTH-1:0] pc_sum;
    logic                       res_valid;
    logic                       res_ready;
    logic [RESP_DATA_WIDTH-1:0] res_data;
`ifdef VMASK_POP_VM_EN
    logic                       req_vm;
    logic [DATA_WIDTH-1:0]      beat_v0;
`endif

    modport slave (
`ifdef VMASK_POP_VM_EN
        input  req_vm,
        input  beat_v0,
`endif
        input  req_valid,
        output req_ready,
        input  req_vl,
        input  beat_valid,
        output beat_ready,
        input  beat_data,
        output pc_m0,
        output pc_valid,
        output pc_count,
        input  pc_sum,
        output res_valid,
        input  res_ready,
        output res_data
    );

    modport master (
`ifdef VMASK_POP_VM_EN
        output req_vm,
        output beat_v0,
`endif
        output req_valid,
        input  req_ready,
        output req_vl,
        output beat_valid,
        input  beat_ready,
        output beat_data,
        input  pc_m0,
        input  pc_valid,
        input  pc_count,
        output pc_sum,
        input  res_valid,
        output res_ready,
        input  res_data
    );
endinterface

// File: rtl/vmask_pop_ctrl.sv
// ----------------------------------------------------------------------------
// vmask_pop_ctrl
//   Sequencer for the mask-popcount datapath executing vcpop.m. Accepts one
//   request carrying vl, streams ceil(vl/DATA_WIDTH) mask beats into the
//   datapath, chains the running sum back through pc_count, masks tail
//   elements at or beyond vl on the last beat, and returns the count over a
//   valid/ready result port.
//
//   Ports:
//     clk  - clock, all logic on posedge
//     rst  - synchronous active-high reset; aborts any op in flight
//     bus  - vmask_pop_ctrl_if.slave (request, beats, datapath, result)
//
//   Optional feature (macro VMASK_POP_VM_EN): adds req_vm and beat_v0. With
//   the latched vm=0 each beat is further ANDed with beat_v0 so only active
//   elements are counted; vm=1 matches the default build.
//
//   The datapath registers pc_sum = popcount(pc_m0) + pc_count one cycle
//   later, so pc_m0/pc_count are driven combinationally from the state.
// ----------------------------------------------------------------------------
module vmask_pop_ctrl #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH_BITS = 6,
    parameter int unsigned VL_WIDTH        = 12,
    parameter int unsigned RESP_DATA_WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    vmask_pop_ctrl_if.slave  bus
);
    localparam int unsigned BEATS_WIDTH = VL_WIDTH - DATA_WIDTH_BITS + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [DATA_WIDTH_BITS-1:0] rem_q;
    logic [BEATS_WIDTH-1:0]     beats_left;
    logic [BEATS_WIDTH-1:0]     req_beats;
    logic [RESP_DATA_WIDTH-1:0] res_data_q;
    logic                       req_fire;
    logic                       beat_fire;
    logic                       last_beat;
    logic [DATA_WIDTH-1:0]      tail;
    logic [DATA_WIDTH-1:0]      active;

    assign req_fire  = (state == IDLE) && bus.req_valid;
    assign beat_fire = (state == RUN) && bus.beat_valid;
    assign last_beat = (beats_left == BEATS_WIDTH'(1));

    // ceil(vl / DATA_WIDTH): whole beats plus one if a partial beat remains
    assign req_beats = BEATS_WIDTH'(bus.req_vl >> DATA_WIDTH_BITS)
                     + BEATS_WIDTH'(bus.req_vl[DATA_WIDTH_BITS-1:0] != '0);

    // Only vl mod DATA_WIDTH is needed after acceptance: it shapes the tail
    always_comb begin
        tail = '1;
        if (last_beat && (rem_q != '0)) begin
            tail = (DATA_WIDTH'(1) << rem_q) - DATA_WIDTH'(1);
        end
    end

`ifdef VMASK_POP_VM_EN
    logic vm_q;

    assign active = vm_q ? '1 : bus.beat_v0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vm_q <= 1'b1;
        end else if (req_fire) begin
            vm_q <= bus.req_vm;
        end
    end
`else
    assign active = '1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rem_q      <= '0;
            beats_left <= '0;
            res_data_q <= '0;
        end else begin
            state <= state_nxt;
            if (req_fire) begin
                rem_q      <= bus.req_vl[DATA_WIDTH_BITS-1:0];
                beats_left <= req_beats;
            end else if (beat_fire) begin
                beats_left <= beats_left - BEATS_WIDTH'(1);
            end
            // Datapath latency means pc_sum already includes the last beat here
            if (state == DRAIN) begin
                res_data_q <= bus.pc_sum;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.beat_ready = 1'b0;
        bus.pc_m0      = '0;
        bus.pc_valid   = 1'b0;
        bus.pc_count   = '0;
        bus.res_valid  = 1'b0;
        case (state)
            IDLE: begin
                // Zero mask and count flush the datapath sum for the next op
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = (bus.req_vl == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                bus.beat_ready = 1'b1;
                bus.pc_count   = bus.pc_sum;
                if (bus.beat_valid) begin
                    bus.pc_m0    = bus.beat_data & active & tail;
                    bus.pc_valid = 1'b1;
                    if (last_beat) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.res_data = res_data_q;
endmodule
